// File: rtl/ct_lsu_dcache_ld_tag_ctrl.sv
// Load-tag SRAM initiator: load/write arbitration, array pin drive and a two-stage per-way hit pipe.
// Optional LSU_DCACHE_TAG_BYPASS_EN forwards a same-index write into the S1 compare instead of flagging replay.
module ct_lsu_dcache_ld_tag_ctrl #(
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned TAG_W      = 26,
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic                     forever_cpuclk,
    input  logic                     cpurst,
    input  logic                     ld_req_vld,
    input  logic [IDX_W-1:0]         ld_req_idx,
    input  logic [TAG_W-1:0]         ld_req_ptag,
    output logic                     ld_req_rdy,
    input  logic                     ld_cancel,
    input  logic                     wr_req_vld,
    input  logic [IDX_W-1:0]         wr_req_idx,
    input  logic [1:0]               wr_req_way,
    input  logic [TAG_W:0]           wr_req_din,
    output logic                     wr_req_rdy,
    output logic                     tag_gateclk_en,
    output logic                     tag_sel_b,
    output logic                     tag_gwen_b,
    output logic [1:0]               tag_wen_b,
    output logic [8:0]               tag_idx,
    output logic [2*(TAG_W+1)-1:0]   tag_din,
    input  logic [2*(TAG_W+1)-1:0]   tag_dout,
    output logic                     ld_resp_vld,
    output logic [1:0]               ld_resp_hit,
    output logic                     ld_resp_replay
);
    localparam int unsigned EW         = TAG_W + 1;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    logic             ld_win;
    logic             wr_win;
    logic [3:0]       starve_q, starve_d;
    logic             s1_vld_q, s1_vld_d;
    logic [IDX_W-1:0] s1_idx_q;
    logic [TAG_W-1:0] s1_ptag_q;
    logic             s2_vld_q, s2_vld_d;
    logic [1:0]       s2_hit_q, s2_hit_d;
    logic             s2_replay_q, s2_replay_d;
    logic             wr_hit_s1;
    logic [1:0]       hit_s1;
    logic [EW-1:0]    cmp_ent [2];

    // Write wins by default; a load that has waited STARVE_MAX write-won cycles takes the port.
    always_comb begin : arb
        ld_win   = ld_req_vld && (!wr_req_vld || (starve_q == STARVE_LIM));
        wr_win   = wr_req_vld && !ld_win;
        starve_d = starve_q;
        if (!ld_req_vld || ld_win) begin
            starve_d = '0;
        end else if (starve_q != '1) begin
            starve_d = starve_q + 4'd1;
        end
    end

    assign ld_req_rdy = ld_win;
    assign wr_req_rdy = wr_win;

    always_comb begin : sram_drive
        tag_gateclk_en = 1'b0;
        tag_sel_b      = 1'b1;
        tag_gwen_b     = 1'b1;
        tag_wen_b      = '1;
        tag_idx        = '0;
        tag_din        = '0;
        if (ld_win) begin
            tag_gateclk_en = 1'b1;
            tag_sel_b      = 1'b0;
            tag_idx        = 9'(ld_req_idx);
        end else if (wr_win) begin
            // An all-zero way mask degenerates into a plain array read.
            tag_gateclk_en = 1'b1;
            tag_sel_b      = 1'b0;
            tag_gwen_b     = ~|wr_req_way;
            tag_wen_b      = ~wr_req_way;
            tag_idx        = 9'(wr_req_idx);
            tag_din        = {2{wr_req_din}};
        end
    end

    always_comb begin : s1_compare
        wr_hit_s1 = wr_win && (|wr_req_way) && s1_vld_q && (wr_req_idx == s1_idx_q);
        hit_s1    = '0;
        for (int unsigned w = 0; w < 2; w++) begin
            cmp_ent[w] = tag_dout[w*EW +: EW];
`ifdef LSU_DCACHE_TAG_BYPASS_EN
            if (wr_hit_s1 && wr_req_way[w]) begin
                cmp_ent[w] = wr_req_din;
            end
`endif
            hit_s1[w] = (cmp_ent[w] == {1'b1, s1_ptag_q});
        end
    end

    always_comb begin : pipe_next
        s1_vld_d = ld_win && !ld_cancel;
        s2_vld_d = s1_vld_q && !ld_cancel;
        s2_hit_d = s2_vld_d ? hit_s1 : '0;
`ifdef LSU_DCACHE_TAG_BYPASS_EN
        s2_replay_d = 1'b0;
`else
        s2_replay_d = s2_vld_d && wr_hit_s1;
`endif
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            starve_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_idx_q    <= '0;
            s1_ptag_q   <= '0;
            s2_vld_q    <= 1'b0;
            s2_hit_q    <= '0;
            s2_replay_q <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            s1_vld_q    <= s1_vld_d;
            if (ld_win) begin
                s1_idx_q  <= ld_req_idx;
                s1_ptag_q <= ld_req_ptag;
            end
            s2_vld_q    <= s2_vld_d;
            s2_hit_q    <= s2_hit_d;
            s2_replay_q <= s2_replay_d;
        end
    end

    assign ld_resp_vld    = s2_vld_q;
    assign ld_resp_hit    = s2_hit_q;
    assign ld_resp_replay = s2_replay_q;

endmodule

// File: tb/tb_ct_lsu_dcache_ld_tag_ctrl.sv
// Scoreboard bench for ct_lsu_dcache_ld_tag_ctrl with a behavioural two-way tag array model.
module tb_ct_lsu_dcache_ld_tag_ctrl;
    logic        forever_cpuclk = 1'b0;
    logic        cpurst = 1'b1;
    logic        ld_req_vld = 1'b0;
    logic [8:0]  ld_req_idx = '0;
    logic [25:0] ld_req_ptag = '0;
    logic        ld_req_rdy;
    logic        ld_cancel = 1'b0;
    logic        wr_req_vld = 1'b0;
    logic [8:0]  wr_req_idx = '0;
    logic [1:0]  wr_req_way = '0;
    logic [26:0] wr_req_din = '0;
    logic        wr_req_rdy;
    logic        tag_gateclk_en;
    logic        tag_sel_b;
    logic        tag_gwen_b;
    logic [1:0]  tag_wen_b;
    logic [8:0]  tag_idx;
    logic [53:0] tag_din;
    logic [53:0] tag_dout = '0;
    logic        ld_resp_vld;
    logic [1:0]  ld_resp_hit;
    logic        ld_resp_replay;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         cyc;
        logic [1:0] hit;
        logic       rep;
    } exp_t;
    exp_t sb[$];

    logic [53:0] mem [512] = '{default: '0};

    ct_lsu_dcache_ld_tag_ctrl #(.IDX_W(9), .TAG_W(26), .STARVE_MAX(7)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .ld_req_vld     (ld_req_vld),
        .ld_req_idx     (ld_req_idx),
        .ld_req_ptag    (ld_req_ptag),
        .ld_req_rdy     (ld_req_rdy),
        .ld_cancel      (ld_cancel),
        .wr_req_vld     (wr_req_vld),
        .wr_req_idx     (wr_req_idx),
        .wr_req_way     (wr_req_way),
        .wr_req_din     (wr_req_din),
        .wr_req_rdy     (wr_req_rdy),
        .tag_gateclk_en (tag_gateclk_en),
        .tag_sel_b      (tag_sel_b),
        .tag_gwen_b     (tag_gwen_b),
        .tag_wen_b      (tag_wen_b),
        .tag_idx        (tag_idx),
        .tag_din        (tag_din),
        .tag_dout       (tag_dout),
        .ld_resp_vld    (ld_resp_vld),
        .ld_resp_hit    (ld_resp_hit),
        .ld_resp_replay (ld_resp_replay)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;
    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    // Tag array: per-way write enables, read data appears the cycle after a read.
    always @(posedge forever_cpuclk) begin
        if (!tag_sel_b) begin
            if (!tag_gwen_b) begin
                if (!tag_wen_b[0]) mem[tag_idx][26:0]  <= tag_din[26:0];
                if (!tag_wen_b[1]) mem[tag_idx][53:27] <= tag_din[53:27];
            end else begin
                tag_dout <= mem[tag_idx];
            end
        end
    end

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic do_write(input logic [8:0] idx, input logic [1:0] way, input logic [26:0] din);
        logic [1:0] wn;
        wn = ~way;
        wr_req_vld = 1'b1; wr_req_idx = idx; wr_req_way = way; wr_req_din = din;
        @(negedge forever_cpuclk);
        chk("wr_rdy", wr_req_rdy, 1);
        chk("wr_ld_rdy", ld_req_rdy, 0);
        chk("wr_sel_b", tag_sel_b, 0);
        chk("wr_gwen_b", tag_gwen_b, (way == 2'b00));
        chk("wr_wen_b", tag_wen_b, wn);
        chk("wr_idx", tag_idx, idx);
        if (way != 2'b00) chk("wr_din", tag_din, {din, din});
        tick();
        wr_req_vld = 1'b0;
    endtask

    task automatic do_load(input logic [8:0] idx, input logic [25:0] ptag,
                           input logic [1:0] hit, input logic rep);
        ld_req_vld = 1'b1; ld_req_idx = idx; ld_req_ptag = ptag;
        @(negedge forever_cpuclk);
        chk("ld_rdy", ld_req_rdy, 1);
        chk("ld_sel_b", tag_sel_b, 0);
        chk("ld_gwen_b", tag_gwen_b, 1);
        chk("ld_wen_b", tag_wen_b, 2'b11);
        chk("ld_idx", tag_idx, idx);
        chk("ld_gclk", tag_gateclk_en, 1);
        sb.push_back('{cyc: cyc + 2, hit: hit, rep: rep});
        tick();
        ld_req_vld = 1'b0;
    endtask

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge forever_cpuclk);
            if (ld_resp_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got response hit=%b at cycle %0d, expected none", ld_resp_hit, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_hit", ld_resp_hit, e.hit);
                    chk("resp_replay", ld_resp_replay, e.rep);
                    if (ld_resp_hit == 2'b11)
                        $display("note: multi-way hit observed at cycle %0d (illegal array state)", cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge forever_cpuclk);
            chk("rst_sel_b", tag_sel_b, 1);
            chk("rst_wen_b", tag_wen_b, 2'b11);
            chk("rst_gwen_b", tag_gwen_b, 1);
            chk("rst_resp_vld", ld_resp_vld, 0);
        end
        tick();
        cpurst = 1'b0;
        @(negedge forever_cpuclk);
        chk("post_rst_sel_b", tag_sel_b, 1);
        chk("post_rst_gclk", tag_gateclk_en, 0);
        chk("post_rst_resp_vld", ld_resp_vld, 0);
        tick();

        // 2: write then hit / miss on the same set
        do_write(9'h1A5, 2'b01, {1'b1, 26'h2ABCDEF});
        do_load(9'h1A5, 26'h2ABCDEF, 2'b01, 1'b0);
        do_load(9'h1A5, 26'h2ABCDEE, 2'b00, 1'b0);
        repeat (3) tick();

        // 3: starvation bound, load wins on the 8th contended cycle
        wr_req_vld = 1'b1; wr_req_idx = 9'h0AA; wr_req_way = 2'b01; wr_req_din = {1'b1, 26'h0000AAA};
        ld_req_vld = 1'b1; ld_req_idx = 9'h0F0; ld_req_ptag = 26'h1111111;
        for (int c = 1; c <= 9; c++) begin
            @(negedge forever_cpuclk);
            chk("starve_ld_rdy", ld_req_rdy, (c == 8));
            chk("starve_wr_rdy", wr_req_rdy, (c != 8));
            if (c == 8) sb.push_back('{cyc: cyc + 2, hit: 2'b00, rep: 1'b0});
            tick();
        end
        wr_req_vld = 1'b0; ld_req_vld = 1'b0;
        repeat (3) tick();

        // 4: same-index write one cycle behind a load
        do_write(9'h010, 2'b01, {1'b1, 26'h1234567});
`ifdef LSU_DCACHE_TAG_BYPASS_EN
        do_load(9'h010, 26'h0555555, 2'b10, 1'b0);
`else
        do_load(9'h010, 26'h0555555, 2'b00, 1'b1);
`endif
        do_write(9'h010, 2'b10, {1'b1, 26'h0555555});
        repeat (3) tick();

        // 5: four back-to-back loads, flush from the third accept onwards
        for (int i = 0; i < 4; i++) begin
            ld_req_vld = 1'b1; ld_req_idx = 9'h1A5; ld_req_ptag = 26'h2ABCDEF;
            ld_cancel = (i >= 2);
            @(negedge forever_cpuclk);
            chk("cancel_ld_rdy", ld_req_rdy, 1);
            if (i == 0) sb.push_back('{cyc: cyc + 2, hit: 2'b01, rep: 1'b0});
            tick();
        end
        ld_req_vld = 1'b0; ld_cancel = 1'b0;
        repeat (3) tick();

        // 6: invalid entry with matching tag, then both ways matching
        do_write(9'h033, 2'b01, {1'b0, 26'h3333333});
        do_load(9'h033, 26'h3333333, 2'b00, 1'b0);
        do_write(9'h044, 2'b11, {1'b1, 26'h0444444});
        do_load(9'h044, 26'h0444444, 2'b11, 1'b0);
        repeat (3) tick();

        // Empty way mask: accepted as a plain read, never yields a response
        do_write(9'h055, 2'b00, {1'b1, 26'h0055555});
        repeat (3) tick();

        // Reset while a lookup sits in S1 flushes it
        ld_req_vld = 1'b1; ld_req_idx = 9'h1A5; ld_req_ptag = 26'h2ABCDEF;
        @(negedge forever_cpuclk);
        chk("rst_mid_ld_rdy", ld_req_rdy, 1);
        tick();
        ld_req_vld = 1'b0;
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge forever_cpuclk);
            chk("rst_mid_resp_vld", ld_resp_vld, 0);
            tick();
        end

        repeat (4) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
